// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared state encoding and constants for the FFT frame controller
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Error codes carried on the FFT core's 2-bit error sideband
  localparam logic [1:0] ERR_NONE           = 2'b00;
  localparam logic [1:0] ERR_MISSING_SOP    = 2'b01;
  localparam logic [1:0] ERR_MISSING_EOP    = 2'b10;
  localparam logic [1:0] ERR_UNEXPECTED_EOP = 2'b11;

  localparam int DEF_FFT_POINTS = 1024;

endpackage

// File: rtl/fft_frame_checker.sv
// rtl/fft_frame_checker.sv - FFT source framing check, output frame counter and sticky errors
module fft_frame_checker
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_POINTS = DEF_FFT_POINTS,
  parameter int FCNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic              i_ready,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [1:0]        i_error,
  output logic [FCNT_W-1:0] o_frames_out,
  output logic              o_err_framing,
  output logic              o_err_core
);

  localparam int IDX_W = $clog2(FFT_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);

  logic [IDX_W-1:0]  r_oidx;
  logic [FCNT_W-1:0] r_frames_out;
  logic              r_err_framing;
  logic              r_err_core;
  logic              w_acc;
  logic              w_bad;

  assign w_acc = i_valid && i_ready;
  assign w_bad = (i_sop != (r_oidx == '0)) || (i_eop != (r_oidx == LAST_IDX));

  // Every sop restarts the count, which also resynchronises after a misframed packet
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oidx <= '0;
    end else if (w_acc) begin
      r_oidx <= i_sop ? IDX_W'(1) : r_oidx + IDX_W'(1);
    end
  end

  // A new run restarts frames_out alongside frames_in so the drain comparison stays meaningful
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frames_out  <= '0;
      r_err_framing <= 1'b0;
      r_err_core    <= 1'b0;
    end else if (i_clr) begin
      r_frames_out  <= '0;
      r_err_framing <= 1'b0;
      r_err_core    <= 1'b0;
    end else if (w_acc) begin
      if (w_bad)               r_err_framing <= 1'b1;
      if (i_error != ERR_NONE) r_err_core    <= 1'b1;
      if (i_eop)               r_frames_out  <= r_frames_out + FCNT_W'(1);
    end
  end

  assign o_frames_out  = r_frames_out;
  assign o_err_framing = r_err_framing;
  assign o_err_core    = r_err_core;

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frames the sample stream into FFT packets and forwards the FFT output
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_POINTS = DEF_FFT_POINTS,
  parameter int IN_W       = 48,
  parameter int OUT_W      = 47,
  parameter int FCNT_W     = 16
) (
  input  logic              i_clk_clk,
  input  logic              i_rst_reset,
  input  logic              i_cfg_start,
  input  logic              i_cfg_stop,
  input  logic [FCNT_W-1:0] i_cfg_num_frames,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [IN_W-1:0]   i_in_data,
  output logic              o_fft_sink_valid,
  input  logic              i_fft_sink_ready,
  output logic              o_fft_sink_sop,
  output logic              o_fft_sink_eop,
  output logic [1:0]        o_fft_sink_error,
  output logic [IN_W-1:0]   o_fft_sink_data,
  input  logic              i_fft_src_valid,
  output logic              o_fft_src_ready,
  input  logic              i_fft_src_sop,
  input  logic              i_fft_src_eop,
  input  logic [1:0]        i_fft_src_error,
  input  logic [OUT_W-1:0]  i_fft_src_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_sop,
  output logic              o_out_eop,
  output logic [OUT_W-1:0]  o_out_data,
  output logic              o_busy,
  output logic [FCNT_W-1:0] o_frames_in,
  output logic [FCNT_W-1:0] o_frames_out,
  output logic              o_err_framing,
  output logic              o_err_core
);

  localparam int IDX_W = $clog2(FFT_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [FCNT_W-1:0] r_frames_in;
  logic [FCNT_W-1:0] r_num_frames;
  logic              r_stop_pend;
  logic [FCNT_W-1:0] w_frames_out;
  logic [FCNT_W-1:0] w_frames_in_inc;
  logic              w_run;
  logic              w_start;
  logic              w_xfer;
  logic              w_sop;
  logic              w_eop;
  logic              w_stop;
  logic              w_last_frame;

  assign w_run           = (r_state == ST_RUN);
  assign w_start         = (r_state == ST_IDLE) && i_cfg_start;
  assign w_xfer          = w_run && i_in_valid && i_fft_sink_ready;
  assign w_sop           = (r_idx == '0);
  assign w_eop           = (r_idx == LAST_IDX);
  assign w_stop          = r_stop_pend || i_cfg_stop;
  assign w_frames_in_inc = r_frames_in + FCNT_W'(1);
  assign w_last_frame    = (r_num_frames != '0) && (w_frames_in_inc == r_num_frames);

  always_comb begin
    w_state_nxt      = r_state;
    o_in_ready       = 1'b0;
    o_fft_sink_valid = 1'b0;
    o_fft_sink_sop   = 1'b0;
    o_fft_sink_eop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cfg_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_in_ready       = i_fft_sink_ready;
        o_fft_sink_valid = i_in_valid;
        o_fft_sink_sop   = i_in_valid && w_sop;
        o_fft_sink_eop   = i_in_valid && w_eop;
        // A stop lands on a frame boundary: either the eop beat or an idle idx==0 cycle
        if (w_xfer && w_eop && (w_stop || w_last_frame)) w_state_nxt = ST_DRAIN;
        else if (w_stop && w_sop && !w_xfer)             w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_frames_out == r_frames_in) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_clk or posedge i_rst_reset) begin
    if (i_rst_reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_frames_in  <= '0;
      r_num_frames <= '0;
      r_stop_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_num_frames <= i_cfg_num_frames;
        r_idx        <= '0;
        r_frames_in  <= '0;
        r_stop_pend  <= i_cfg_stop;
      end else begin
        if (w_xfer) begin
          r_idx <= r_idx + IDX_W'(1);
          if (w_eop) r_frames_in <= w_frames_in_inc;
        end
        if (w_state_nxt == ST_DRAIN) r_stop_pend <= 1'b0;
        else if (w_run && i_cfg_stop) r_stop_pend <= 1'b1;
      end
    end
  end

  assign o_fft_sink_error = ERR_NONE;
  assign o_fft_sink_data  = i_in_data;

  assign o_out_valid     = i_fft_src_valid;
  assign o_out_sop       = i_fft_src_sop;
  assign o_out_eop       = i_fft_src_eop;
  assign o_out_data      = i_fft_src_data;
  assign o_fft_src_ready = i_out_ready;

  fft_frame_checker #(
    .FFT_POINTS (FFT_POINTS),
    .FCNT_W     (FCNT_W)
  ) u_checker (
    .i_clk         (i_clk_clk),
    .i_rst         (i_rst_reset),
    .i_clr         (w_start),
    .i_valid       (i_fft_src_valid),
    .i_ready       (i_out_ready),
    .i_sop         (i_fft_src_sop),
    .i_eop         (i_fft_src_eop),
    .i_error       (i_fft_src_error),
    .o_frames_out  (w_frames_out),
    .o_err_framing (o_err_framing),
    .o_err_core    (o_err_core)
  );

  assign o_busy       = (r_state != ST_IDLE) || (r_frames_in != w_frames_out);
  assign o_frames_in  = r_frames_in;
  assign o_frames_out = w_frames_out;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed and table-driven bench for fft_frame_ctrl at 8 points
module tb_fft_frame_ctrl;

  localparam int PTS    = 8;
  localparam int IN_W   = 48;
  localparam int OUT_W  = 47;
  localparam int FCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic              cfg_stop = 1'b0;
  logic [FCNT_W-1:0] cfg_num = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN_W-1:0]   in_data = '0;
  logic              sink_valid;
  logic              sink_ready = 1'b1;
  logic              sink_sop;
  logic              sink_eop;
  logic [1:0]        sink_error;
  logic [IN_W-1:0]   sink_data;
  logic              src_valid = 1'b0;
  logic              src_ready;
  logic              src_sop = 1'b0;
  logic              src_eop = 1'b0;
  logic [1:0]        src_error = 2'b00;
  logic [OUT_W-1:0]  src_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_sop;
  logic              out_eop;
  logic [OUT_W-1:0]  out_data;
  logic              busy;
  logic [FCNT_W-1:0] frames_in;
  logic [FCNT_W-1:0] frames_out;
  logic              err_framing;
  logic              err_core;

  int n_checks = 0;
  int n_errors = 0;
  int seq = 0;

  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .FFT_POINTS (PTS),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .FCNT_W     (FCNT_W)
  ) dut (
    .i_clk_clk        (clk),
    .i_rst_reset      (rst),
    .i_cfg_start      (cfg_start),
    .i_cfg_stop       (cfg_stop),
    .i_cfg_num_frames (cfg_num),
    .i_in_valid       (in_valid),
    .o_in_ready       (in_ready),
    .i_in_data        (in_data),
    .o_fft_sink_valid (sink_valid),
    .i_fft_sink_ready (sink_ready),
    .o_fft_sink_sop   (sink_sop),
    .o_fft_sink_eop   (sink_eop),
    .o_fft_sink_error (sink_error),
    .o_fft_sink_data  (sink_data),
    .i_fft_src_valid  (src_valid),
    .o_fft_src_ready  (src_ready),
    .i_fft_src_sop    (src_sop),
    .i_fft_src_eop    (src_eop),
    .i_fft_src_error  (src_error),
    .i_fft_src_data   (src_data),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_sop        (out_sop),
    .o_out_eop        (out_eop),
    .o_out_data       (out_data),
    .o_busy           (busy),
    .o_frames_in      (frames_in),
    .o_frames_out     (frames_out),
    .o_err_framing    (err_framing),
    .o_err_core       (err_core)
  );

  typedef struct packed {
    logic v;
    logic r;
    logic e_ready;
    logic e_valid;
    logic e_sop;
    logic e_eop;
    logic e_fin;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [FCNT_W-1:0] n);
    cfg_start = 1'b1;
    cfg_num   = n;
    step();
    cfg_start = 1'b0;
  endtask

  // Feeds n beats from idx 0 with ready high; cfg_stop pulses on beat stop_at
  task automatic feed(input int n, input int stop_at);
    for (int i = 0; i < n; i++) begin
      in_valid   = 1'b1;
      sink_ready = 1'b1;
      cfg_stop   = (i == stop_at);
      in_data    = IN_W'(seq);
      #1;
      chk("feed_ready", in_ready, 1);
      chk("feed_sop", sink_sop, (i % PTS) == 0);
      chk("feed_eop", sink_eop, (i % PTS) == PTS - 1);
      chk("feed_data", sink_data, IN_W'(seq));
      seq++;
      step();
    end
    in_valid = 1'b0;
    cfg_stop = 1'b0;
  endtask

  // Plays the FFT core returning one packet of n beats
  task automatic src_frame(input int n, input int eop_at, input int err_at);
    for (int b = 0; b < n; b++) begin
      src_valid = 1'b1;
      src_sop   = (b == 0);
      src_eop   = (b == eop_at);
      src_error = (b == err_at) ? 2'b01 : 2'b00;
      src_data  = {15'($urandom), $urandom};
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, src_data);
      chk("out_sopeop", {out_sop, out_eop}, {src_sop, src_eop});
      chk("src_ready", src_ready, out_ready);
      step();
    end
    src_valid = 1'b0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
    src_error = 2'b00;
  endtask

  initial begin
    int sent;
    int cyc;

    tbl[0]  = 7'b1111100;
    tbl[1]  = 7'b1111000;
    tbl[2]  = 7'b1111000;
    tbl[3]  = 7'b1111000;
    tbl[4]  = 7'b0110000;
    tbl[5]  = 7'b1111000;
    tbl[6]  = 7'b1111000;
    tbl[7]  = 7'b1111000;
    tbl[8]  = 7'b1111010;
    tbl[9]  = 7'b1001101;
    tbl[10] = 7'b1111101;
    for (int k = 11; k < 17; k++) tbl[k] = 7'b1111001;
    tbl[17] = 7'b1111011;
    tbl[4]  = 7'b0110000;

    // Reset values
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sink_valid", sink_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", {frames_in, frames_out}, 0);
    chk("rst_errs", {err_framing, err_core}, 0);
    chk("rst_sink_error", sink_error, 0);
    #9;
    rst = 1'b0;
    step();

    // Two-frame run with a couple of stall rows
    start(16'd2);
    for (int k = 0; k < 18; k++) begin
      in_valid   = tbl[k].v;
      sink_ready = tbl[k].r;
      in_data    = IN_W'(seq);
      #1;
      chk("t1_in_ready", in_ready, tbl[k].e_ready);
      chk("t1_sink_valid", sink_valid, tbl[k].e_valid);
      chk("t1_sop", sink_sop, tbl[k].e_sop);
      chk("t1_eop", sink_eop, tbl[k].e_eop);
      chk("t1_frames_in", frames_in, FCNT_W'(tbl[k].e_fin));
      if (tbl[k].v && tbl[k].r) begin
        chk("t1_data", sink_data, IN_W'(seq));
        seq++;
      end
      step();
    end
    in_valid   = 1'b1;
    sink_ready = 1'b1;
    #1;
    chk("t1_drain_ready", in_ready, 0);
    chk("t1_drain_valid", sink_valid, 0);
    chk("t1_frames_in_end", frames_in, 2);
    chk("t1_busy_drain", busy, 1);
    in_valid = 1'b0;
    src_frame(PTS, PTS - 1, -1);
    src_frame(PTS, PTS - 1, -1);
    chk("t1_frames_out", frames_out, 2);
    step();
    chk("t1_idle_busy", busy, 0);

    // Random stalls on both sides, three frames
    start(16'd3);
    sent = 0;
    cyc  = 0;
    while (sent < 3 * PTS && cyc < 1000) begin
      in_valid   = 1'($urandom_range(0, 1));
      sink_ready = 1'($urandom_range(0, 1));
      in_data    = {16'hA5A5, 32'(sent)};
      #1;
      chk("t2_valid", sink_valid, in_valid);
      chk("t2_ready", in_ready, sink_ready);
      if (in_valid && sink_ready) begin
        chk("t2_data", sink_data, {16'hA5A5, 32'(sent)});
        chk("t2_sop", sink_sop, (sent % PTS) == 0);
        chk("t2_eop", sink_eop, (sent % PTS) == PTS - 1);
        sent++;
      end
      step();
      cyc++;
    end
    if (sent < 3 * PTS) chk("t2_timeout", 64'(sent), 64'(3 * PTS));
    in_valid   = 1'b1;
    sink_ready = 1'b1;
    #1;
    chk("t2_drain_ready", in_ready, 0);
    chk("t2_frames_in", frames_in, 3);
    in_valid = 1'b0;
    for (int f = 0; f < 3; f++) src_frame(PTS, PTS - 1, -1);
    step();
    chk("t2_idle_busy", busy, 0);

    // Continuous mode, stop mid-frame completes the frame
    start(16'd0);
    feed(PTS, 3);
    in_valid = 1'b1;
    #1;
    chk("t3_stopped_ready", in_ready, 0);
    step();
    chk("t3_frames_in", frames_in, 1);
    in_valid = 1'b0;
    src_frame(PTS, PTS - 1, -1);
    step();
    chk("t3_idle_busy", busy, 0);

    // Stop at idx 0 with nothing transferring is immediate
    start(16'd0);
    in_valid = 1'b0;
    cfg_stop = 1'b1;
    #1;
    chk("t3b_run_ready", in_ready, 1);
    step();
    cfg_stop = 1'b0;
    #1;
    chk("t3b_drain_ready", in_ready, 0);
    step();
    in_valid = 1'b1;
    #1;
    chk("t3b_idle_busy", busy, 0);
    chk("t3b_idle_ready", in_ready, 0);
    chk("t3b_frames_in", frames_in, 0);
    in_valid = 1'b0;

    // Early eop, then resync on the next sop
    start(16'd1);
    feed(PTS, -1);
    src_frame(6, 5, -1);
    chk("t4_err_framing", err_framing, 1);
    chk("t4_frames_out", frames_out, 1);
    step();
    chk("t4_idle_busy", busy, 0);
    src_frame(PTS, PTS - 1, -1);
    chk("t4_sticky", err_framing, 1);
    chk("t4_extra_eop", frames_out, 2);
    chk("t4_busy_extra", busy, 1);
    start(16'd1);
    chk("t4_clr_err", err_framing, 0);
    chk("t4_clr_fout", frames_out, 0);
    feed(PTS, -1);
    src_frame(PTS, PTS - 1, -1);
    chk("t4_resynced", err_framing, 0);
    chk("t4_frames_out2", frames_out, 1);
    step();
    chk("t4_idle_busy2", busy, 0);

    // Core error flag: ignored when not accepted, sticky until cfg_start
    start(16'd1);
    feed(PTS, -1);
    out_ready = 1'b0;
    src_valid = 1'b1;
    src_sop   = 1'b1;
    src_error = 2'b01;
    #1;
    chk("t5_src_ready_low", src_ready, 0);
    step();
    chk("t5_not_accepted", err_core, 0);
    out_ready = 1'b1;
    src_frame(PTS, PTS - 1, 2);
    chk("t5_err_core", err_core, 1);
    chk("t5_no_framing", err_framing, 0);
    step();
    chk("t5_idle_busy", busy, 0);
    chk("t5_sticky", err_core, 1);
    start(16'd0);
    chk("t5_clr", err_core, 0);

    // Async reset mid-frame at idx 4
    feed(PTS + 4, -1);
    cfg_start = 1'b1;
    cfg_num   = 16'd5;
    step();
    cfg_start = 1'b0;
    chk("t6_start_ignored", frames_in, 1);
    in_valid = 1'b1;
    #1;
    chk("t6_pre_ready", in_ready, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_valid", sink_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_frames_in", frames_in, 0);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    start(16'd1);
    in_valid = 1'b1;
    #1;
    chk("t6_clean_valid", sink_valid, 1);
    chk("t6_clean_sop", sink_sop, 1);
    chk("t6_clean_eop", sink_eop, 0);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
